// File: rtl/debug_link_pkg.sv
// rtl/debug_link_pkg.sv - shared framing constants for the debug dump link (transmitter and receiver)
package debug_link_pkg;

    localparam logic [7:0] SOF_BYTE          = 8'hA5;
    localparam int         MAX_WORDS_DEFAULT = 64;
    localparam bit         MSB_FIRST         = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
        if (MSB_FIRST) return {word[23:0], b};
        else           return {b, word[31:8]};
    endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// rtl/byte_timeout_counter.sv - idle-cycle counter between pops, cleared on pop, flags expiry
module byte_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 70000
) (
    input  logic clock,
    input  logic reset,
    input  logic active_i,
    input  logic pop_i,
    output logic expire_o
);

    localparam int             CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!active_i || pop_i)   count_d = '0;
        else if (count_q != LAST) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign expire_o = active_i && !pop_i && (count_q == LAST);

endmodule

// File: rtl/debug_frame_receiver.sv
// rtl/debug_frame_receiver.sv - decodes SOF/len/payload/checksum frames into capture-RAM word writes
// Optional frame statistics outputs enabled by DEBUG_FRAME_RX_STATS_EN.
module debug_frame_receiver
    import debug_link_pkg::*;
#(
    parameter int MAX_WORDS      = MAX_WORDS_DEFAULT,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 70000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        byteIn,
    input  logic              byteAvailable,
    output logic              byteRead,
    output logic              wordWrite,
    output logic [ADDR_W-1:0] wordAddr,
    output logic [31:0]       wordData,
    output logic              frameDone,
    output logic              frameError,
    output logic [7:0]        wordCount,
`ifdef DEBUG_FRAME_RX_STATS_EN
    output logic [15:0]       goodFrames,
    output logic [15:0]       badFrames,
`endif
    output logic              busy
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        count_q, count_d;
    logic              active, expire;

    assign byteRead = reset && byteAvailable && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign active   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);

    byte_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .active_i (active),
        .pop_i    (byteRead),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        wcnt_d     = wcnt_q;
        wr_d       = 1'b0;
        wdata_d    = wdata_q;
        count_d    = count_q;
        // Address advances in the cycle after each write so it points at the next slot.
        addr_d     = wr_q ? addr_q + 1'b1 : addr_q;
        case (state_q)
            ST_IDLE: begin
                if (byteRead && byteIn == SOF_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byteRead) begin
                    len_d      = byteIn;
                    csum_d     = byteIn;
                    byte_idx_d = 2'd0;
                    wcnt_d     = 8'd0;
                    addr_d     = '0;
                    if (byteIn > MAX_LEN)     state_d = ST_ERR;
                    else if (byteIn == 8'd0)  state_d = ST_CHK;
                    else                      state_d = ST_DATA;
                end else if (expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                if (byteRead) begin
                    word_d     = shift_in(word_q, byteIn);
                    csum_d     = csum_q ^ byteIn;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_d    = 1'b1;
                        wdata_d = shift_in(word_q, byteIn);
                        wcnt_d  = wcnt_q + 8'd1;
                        if (wcnt_q + 8'd1 == len_q) state_d = ST_CHK;
                    end
                end else if (expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_CHK: begin
                if (byteRead) begin
                    if (byteIn == csum_q) begin
                        state_d = ST_DONE;
                        count_d = len_q;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            wcnt_q     <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            wcnt_q     <= wcnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
        end
    end

    assign wordWrite  = wr_q;
    assign wordAddr   = addr_q;
    assign wordData   = wdata_q;
    assign wordCount  = count_q;
    assign frameDone  = (state_q == ST_DONE);
    assign frameError = (state_q == ST_ERR);
    assign busy       = (state_q != ST_IDLE);

`ifdef DEBUG_FRAME_RX_STATS_EN
    logic [15:0] good_q, bad_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (frameDone && good_q != 16'hFFFF)  good_q <= good_q + 16'd1;
            if (frameError && bad_q != 16'hFFFF)  bad_q  <= bad_q + 16'd1;
        end
    end

    assign goodFrames = good_q;
    assign badFrames  = bad_q;
`endif

endmodule

// File: tb/tb_debug_frame_receiver.sv
// tb/tb_debug_frame_receiver.sv - directed self-checking bench for debug_frame_receiver
module tb_debug_frame_receiver;

    localparam int TO = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteAvailable;
    logic        byteRead;
    logic        wordWrite;
    logic [5:0]  wordAddr;
    logic [31:0] wordData;
    logic        frameDone;
    logic        frameError;
    logic [7:0]  wordCount;
    logic        busy;
`ifdef DEBUG_FRAME_RX_STATS_EN
    logic [15:0] goodFrames, badFrames;
`endif

    debug_frame_receiver #(.MAX_WORDS(64), .ADDR_W(6), .TIMEOUT_CYCLES(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .byteIn        (byteIn),
        .byteAvailable (byteAvailable),
        .byteRead      (byteRead),
        .wordWrite     (wordWrite),
        .wordAddr      (wordAddr),
        .wordData      (wordData),
        .frameDone     (frameDone),
        .frameError    (frameError),
        .wordCount     (wordCount),
`ifdef DEBUG_FRAME_RX_STATS_EN
        .goodFrames    (goodFrames),
        .badFrames     (badFrames),
`endif
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          last_pop = 0;
    int          done_cnt = 0, done_cyc = 0;
    int          err_cnt = 0, err_cyc = 0;
    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    always @(negedge clock) begin
        ncyc <= ncyc + 1;
        if (byteRead) last_pop <= ncyc;
        if (wordWrite) begin
            wr_addr_q.push_back(wordAddr);
            wr_data_q.push_back(wordData);
            wr_cyc_q.push_back(ncyc);
        end
        if (frameDone) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= ncyc;
        end
        if (frameError) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= ncyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        byteIn        = b;
        byteAvailable = 1'b1;
        #2;
        check("byteRead", byteRead, 1'b1);
        @(posedge clock);
        #1;
        byteAvailable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    int p_ef, p_ck, d0, e0, k;

    initial begin
        reset         = 1'b0;
        byteIn        = 8'h00;
        byteAvailable = 1'b1;
        idle(3);
        check("rst byteRead", byteRead, 1'b0);
        check("rst wordWrite", wordWrite, 1'b0);
        check("rst wordAddr", wordAddr, 6'd0);
        check("rst wordData", wordData, 32'd0);
        check("rst frameDone", frameDone, 1'b0);
        check("rst frameError", frameError, 1'b0);
        check("rst wordCount", wordCount, 8'd0);
        check("rst busy", busy, 1'b0);
        byteAvailable = 1'b0;
        reset = 1'b1;
        idle(2);

        // Good one-word frame; checksum = 01^DE^AD^BE^EF = 23
        clear_log();
        d0 = done_cnt; e0 = err_cnt;
        put(8'hA5); put(8'h01); put(8'hDE); put(8'hAD); put(8'hBE);
        put(8'hEF); p_ef = last_pop;
        put(8'h23); p_ck = last_pop;
        check("t1 frameDone now", frameDone, 1'b1);
        check("t1 wordCount now", wordCount, 8'd1);
        check("t1 byteRead in DONE", byteRead, 1'b0);
        idle(3);
        check("t1 writes", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t1 addr", wr_addr_q[0], 6'd0);
            check("t1 data", wr_data_q[0], 32'hDEADBEEF);
            check("t1 write latency", wr_cyc_q[0], p_ef + 1);
        end
        check("t1 done count", done_cnt, d0 + 1);
        check("t1 done latency", done_cyc, p_ck + 1);
        check("t1 no error", err_cnt, e0);
        check("t1 wordCount", wordCount, 8'd1);
        check("t1 busy", busy, 1'b0);

        // Bad checksum
        clear_log();
        d0 = done_cnt; e0 = err_cnt;
        put(8'hA5); put(8'h01); put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
        put(8'h20); p_ck = last_pop;
        check("t2 frameError now", frameError, 1'b1);
        idle(3);
        check("t2 err count", err_cnt, e0 + 1);
        check("t2 err latency", err_cyc, p_ck + 1);
        check("t2 no done", done_cnt, d0);
        check("t2 word kept", wr_addr_q.size(), 1);
        check("t2 wordCount held", wordCount, 8'd1);
        check("t2 busy", busy, 1'b0);

        // Junk before SOF, then zero-length frame
        clear_log();
        d0 = done_cnt; e0 = err_cnt;
        put(8'h00);
        check("t3 busy after 00", busy, 1'b0);
        put(8'hFF);
        check("t3 busy after FF", busy, 1'b0);
        put(8'hA5);
        check("t3 busy after SOF", busy, 1'b1);
        put(8'h00); put(8'h00);
        check("t3 frameDone now", frameDone, 1'b1);
        idle(3);
        check("t3 done count", done_cnt, d0 + 1);
        check("t3 no error", err_cnt, e0);
        check("t3 wordCount", wordCount, 8'd0);
        check("t3 no writes", wr_addr_q.size(), 0);

        // Length 65 exceeds MAX_WORDS
        clear_log();
        d0 = done_cnt; e0 = err_cnt;
        put(8'hA5); put(8'h41);
        check("t4 frameError now", frameError, 1'b1);
        idle(3);
        check("t4 err count", err_cnt, e0 + 1);
        check("t4 no done", done_cnt, d0);
        check("t4 no writes", wr_addr_q.size(), 0);
        check("t4 busy", busy, 1'b0);

        // Timeout in DATA, then a good frame: checksum 01^12^34^56^78 = 09
        clear_log();
        d0 = done_cnt; e0 = err_cnt;
        put(8'hA5); put(8'h02); put(8'h11); put(8'h22);
        p_ck = last_pop;
        k = 0;
        while (err_cnt == e0 && k < TO + 10) begin
            @(posedge clock);
            #1;
            k++;
        end
        idle(2);
        check("t5 timeout error", err_cnt, e0 + 1);
        check("t5 timeout cycle", err_cyc, p_ck + TO + 1);
        check("t5 busy", busy, 1'b0);
        check("t5 no writes", wr_addr_q.size(), 0);
        d0 = done_cnt;
        put(8'hA5); put(8'h01); put(8'h12); put(8'h34); put(8'h56); put(8'h78); put(8'h09);
        idle(3);
        check("t5 done", done_cnt, d0 + 1);
        check("t5 writes", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t5 addr", wr_addr_q[0], 6'd0);
            check("t5 data", wr_data_q[0], 32'h12345678);
        end
        check("t5 wordCount", wordCount, 8'd1);

        // Reset mid-DATA, then two-word frame: checksum 02^01^..^08 = 0A
        clear_log();
        d0 = done_cnt; e0 = err_cnt;
        put(8'hA5); put(8'h02); put(8'h11); put(8'h22); put(8'h33);
        check("t6 busy before reset", busy, 1'b1);
        byteAvailable = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("t6 rst busy", busy, 1'b0);
        check("t6 rst byteRead", byteRead, 1'b0);
        check("t6 rst wordCount", wordCount, 8'd0);
        check("t6 rst wordAddr", wordAddr, 6'd0);
        check("t6 rst wordData", wordData, 32'd0);
        check("t6 rst pulses", {wordWrite, frameDone, frameError}, 3'b000);
        idle(2);
        byteAvailable = 1'b0;
        reset = 1'b1;
        idle(2);
        check("t6 no done", done_cnt, d0);
        check("t6 no error", err_cnt, e0);
        check("t6 no writes", wr_addr_q.size(), 0);
        put(8'hA5); put(8'h02);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        put(8'h05); put(8'h06); put(8'h07); put(8'h08);
        put(8'h0A);
        idle(3);
        check("t6 done", done_cnt, d0 + 1);
        check("t6 no error after", err_cnt, e0);
        check("t6 writes", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("t6 addr0", wr_addr_q[0], 6'd0);
            check("t6 data0", wr_data_q[0], 32'h01020304);
            check("t6 addr1", wr_addr_q[1], 6'd1);
            check("t6 data1", wr_data_q[1], 32'h05060708);
        end
        check("t6 wordCount", wordCount, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
